// File: rtl/gray_pkg.sv
// Shared constants and Gray-code conversion helpers for the FIFO pointer logic.
// The helpers work on the widest legal pointer, so narrower callers zero-extend
// their operands and truncate the result.
package gray_pkg;

    localparam int MODE_WR   = 0;
    localparam int MODE_RD   = 1;
    localparam int MAX_PTR_W = 13;

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing in from the other
// clock domain. It is kept as its own module so the crossing can be constrained
// on its own.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_r;

    // Shift the incoming pointer through the flop chain; a synchronous reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[STAGES-2:0], d};
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an asynchronous FIFO: the local binary and Gray pointers, the
// synchronised remote pointer, the full or empty flag, the occupancy, and a
// sticky error bit that records any advance request made while blocked.
module gray_ptr_ctrl
    import gray_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              INC_i,
    input  logic [ADDR_W:0]   RPTR_GRAY_i,
    output logic [ADDR_W:0]   PTR_BIN_o,
    output logic [ADDR_W:0]   PTR_GRAY_o,
    output logic [ADDR_W-1:0] ADDR_o,
    output logic              FLAG_o,
    output logic [ADDR_W:0]   LEVEL_o,
    output logic              ERR_o
);

    localparam int   PTR_W    = ADDR_W + 1;
    localparam logic FLAG_RST = (MODE == MODE_RD) ? 1'b1 : 1'b0;

    // Stop elaboration on any parameter value outside the supported range.
    generate
        if (ADDR_W < 2 || ADDR_W > 12) begin : g_bad_addr_w
            $error("gray_ptr_ctrl: ADDR_W must be in 2..12");
        end
        if (MODE != MODE_WR && MODE != MODE_RD) begin : g_bad_mode
            $error("gray_ptr_ctrl: MODE must be 0 or 1");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("gray_ptr_ctrl: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [PTR_W-1:0] ptr_bin_r;
    logic [PTR_W-1:0] ptr_gray_r;
    logic             flag_r;
    logic             err_r;

    logic [PTR_W-1:0] rsync_s;
    logic [PTR_W-1:0] rbin_s;
    logic             advance_s;
    logic [PTR_W-1:0] bin_next_s;
    logic [PTR_W-1:0] gray_next_s;
    logic [PTR_W-1:0] full_cmp_s;
    logic             flag_next_s;
    logic [PTR_W-1:0] level_s;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (CLK_i),
        .rst (RST_i),
        .d   (RPTR_GRAY_i),
        .q   (rsync_s)
    );

    // The pointer moves only when asked and not blocked. The flag is evaluated
    // against the post-advance value so it asserts on the edge that reaches the limit.
    always_comb begin
        advance_s   = INC_i & ~flag_r;
        bin_next_s  = ptr_bin_r + {{(PTR_W-1){1'b0}}, advance_s};
        gray_next_s = PTR_W'(bin2gray(MAX_PTR_W'(bin_next_s)));
        full_cmp_s  = {~rsync_s[PTR_W-1:PTR_W-2], rsync_s[PTR_W-3:0]};
        if (MODE == MODE_WR) begin
            flag_next_s = (gray_next_s == full_cmp_s);
        end else begin
            flag_next_s = (gray_next_s == rsync_s);
        end
    end

    // Occupancy uses registered state only, so no input reaches an output in the same cycle.
    always_comb begin
        rbin_s = PTR_W'(gray2bin(MAX_PTR_W'(rsync_s)));
        if (MODE == MODE_WR) begin
            level_s = ptr_bin_r - rbin_s;
        end else begin
            level_s = rbin_s - ptr_bin_r;
        end
    end

    // Update pointers, flag and sticky error. Reset takes priority over any advance.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            ptr_bin_r  <= '0;
            ptr_gray_r <= '0;
            flag_r     <= FLAG_RST;
            err_r      <= 1'b0;
        end else begin
            ptr_bin_r  <= bin_next_s;
            ptr_gray_r <= gray_next_s;
            flag_r     <= flag_next_s;
            err_r      <= err_r | (INC_i & flag_r);
        end
    end

    assign PTR_BIN_o  = ptr_bin_r;
    assign PTR_GRAY_o = ptr_gray_r;
    assign ADDR_o     = ptr_bin_r[ADDR_W-1:0];
    assign FLAG_o     = flag_r;
    assign LEVEL_o    = level_s;
    assign ERR_o      = err_r;

endmodule
